sprite_scaler: RTL and testbench
================================

SPRITE_SCALER -- requirements
Module: sprite_scaler

Interface
REQ-001 Parameter WIDTH, default 8: sprite width in sprite pixels, ≥ 2.
REQ-002 Parameter HEIGHT, default 8: sprite height in sprite rows, ≥ 1.
REQ-003 Parameter BPP, default 2: bits per sprite pixel, ≥ 1; colour value 0 means transparent.
REQ-004 Parameter SCALE, default 8: display pixels per sprite pixel, horizontally and vertically, ≥ 1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 frame_start  input  1  one-cycle pulse; restarts the sprite at row 0.
REQ-008 line_start  input  1  one-cycle pulse before the first overlapped pixel of each display line.
REQ-009 pixel_valid  input  1  current display pixel lies inside the sprite area.
REQ-010 sprite_data  input  BPP  head pixel of the external sprite shift register.
REQ-011 sprite_shift  output  1  advance the external sprite register by one pixel.
REQ-012 sprite_pixel  output  BPP  colour for the current display pixel.
REQ-013 pixel_opaque  output  1  sprite_pixel is non-zero and the sprite is not done.
REQ-014 sprite_done  output  1  all HEIGHT rows consumed since the last frame_start.

Function
REQ-015 State: x_sub (0..SCALE-1), y_sub (0..SCALE-1), row (0..HEIGHT), first_pending flag, and line buffer of WIDTH×BPP bits.
REQ-016 Counter widths SHALL be $clog2 of max(range,2); no counter ever exceeds its range.
REQ-017 fresh = (y_sub == 0) and not sprite_done; fresh lines read sprite_data, other lines read the line-buffer head.
REQ-018 sprite_pixel = 0 when sprite_done or not pixel_valid; else sprite_data if fresh, else line-buffer head; combinational, zero latency.
REQ-019 step = pixel_valid and (x_sub == SCALE-1) and not sprite_done.
REQ-020 x_sub increments on each pixel_valid cycle, wraps to 0 after SCALE-1, and clears on line_start.
REQ-021 sprite_shift = step and fresh; combinational; exactly WIDTH pulses per sprite row.
REQ-022 On step: line buffer shifts one pixel toward head; tail loads sprite_data if fresh, else the old head (circular rotate).
REQ-023 frame_start: row←0, y_sub←0, x_sub←0, first_pending←1.
REQ-024 line_start with first_pending: first_pending←0, y_sub unchanged.
REQ-025 line_start without first_pending: y_sub increments; on wrap from SCALE-1 to 0, row increments, saturating at HEIGHT.
REQ-026 sprite_done = (row == HEIGHT); while done, sprite_shift is 0 and the line buffer holds.
REQ-027 frame_start and line_start in the same cycle: frame_start wins, first_pending stays 1.
REQ-028 SCALE = 1: every pixel_valid is a step, every line is fresh, and the line buffer is loaded but never read.
REQ-029 Display lines with fewer than WIDTH×SCALE pixel_valid cycles: behaviour undefined; not checked.

Reset
REQ-030 Reset SHALL asynchronously clear x_sub, y_sub, row, first_pending and the line buffer.
REQ-031 After reset, outputs are sprite_shift=0, sprite_pixel=0, pixel_opaque=0, sprite_done=0 until stimulus.
REQ-032 Reset mid-line abandons the row; behaviour resumes correctly after the next frame_start.

Structure
REQ-033 Package sprite_pkg SHALL hold the default BPP, WIDTH, HEIGHT and SCALE constants and the pixel colour typedef.
REQ-034 Sub-module sprite_line_buf SHALL implement the WIDTH×BPP circular shift register with shift, load_sel and data_in ports; counters and control stay in sprite_scaler.

Verification
REQ-035 Setup WIDTH=4, HEIGHT=2, BPP=2, SCALE=2, rows {1,2,3,0} and {3,3,0,1}; frame, 4 lines -> pixels 1,1,2,2,3,3,0,0 on lines 0-1, then 3,3,3,3,0,0,1,1 on lines 2-3, 8 shifts total.
REQ-036 Same setup, fifth line -> sprite_done=1, sprite_pixel=0, no sprite_shift.
REQ-037 Same setup, line 1 (repeat line) -> sprite_shift never asserts, and pixel_opaque=0 exactly on colour-0 pixels.
REQ-038 frame_start and line_start in the same cycle mid-sprite -> row=0, next line fresh, pattern restarts at pixel 1.
REQ-039 SCALE=1, WIDTH=8 -> one sprite_shift per pixel_valid cycle, and sprite_pixel equals sprite_data each cycle.
REQ-040 Reset asserted at x_sub=1 of line 2 -> all outputs 0 immediately; after frame_start, the REQ-035 sequence reproduces exactly.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared constants and types for the sprite scaler slice.
//   DEF_*      default sprite geometry and colour depth
//   pixel_t    colour value at the default depth (0 = transparent)
//   cnt_width  bits needed to hold 0..range-1, never less than 1
package sprite_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_HEIGHT = 8;
  localparam int DEF_BPP    = 2;
  localparam int DEF_SCALE  = 8;

  typedef logic [DEF_BPP-1:0] pixel_t;

  function automatic int cnt_width(input int range);
    return (range < 2) ? 1 : $clog2(range);
  endfunction

endpackage

// File: rtl/sprite_line_buf.sv
// sprite_line_buf
// Circular shift register holding one sprite row, WIDTH pixels of BPP bits.
// Pixel 0 sits at the head. Each shift moves every pixel one place toward
// the head; the tail takes either data_in or the pixel leaving the head.
// Ports:
//   clk, reset  clock and asynchronous active-high reset (clears contents)
//   shift       advance by one pixel this cycle
//   load_sel    1: tail loads data_in, 0: tail loads the old head (rotate)
//   data_in     new pixel for the tail
//   head        pixel currently at the head
module sprite_line_buf
  import sprite_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BPP   = DEF_BPP
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           shift,
  input  logic           load_sel,
  input  logic [BPP-1:0] data_in,
  output logic [BPP-1:0] head
);

  logic [WIDTH*BPP-1:0] mem;
  logic [BPP-1:0]       tail;

  assign head = mem[BPP-1:0];
  assign tail = load_sel ? data_in : head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else if (shift) begin
      mem <= {tail, mem[WIDTH*BPP-1:BPP]};
    end
  end

endmodule

// File: rtl/sprite_scaler.sv
// sprite_scaler
// Magnifies a WIDTH x HEIGHT sprite by SCALE in both directions. The first
// display line of each sprite row pulls pixels from an external shift
// register and captures them in a line buffer; the remaining SCALE-1 lines
// of that row replay the buffer, so the external register advances exactly
// WIDTH times per sprite row.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   frame_start   restart the sprite at row 0
//   line_start    pulse ahead of each display line that overlaps the sprite
//   pixel_valid   current display pixel lies inside the sprite area
//   sprite_data   head pixel of the external sprite register
//   sprite_shift  advance the external sprite register
//   sprite_pixel  colour of the current display pixel (0 outside/after sprite)
//   pixel_opaque  sprite_pixel is non-zero
//   sprite_done   all sprite rows consumed since frame_start
module sprite_scaler
  import sprite_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int BPP    = DEF_BPP,
  parameter int SCALE  = DEF_SCALE
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_start,
  input  logic           line_start,
  input  logic           pixel_valid,
  input  logic [BPP-1:0] sprite_data,
  output logic           sprite_shift,
  output logic [BPP-1:0] sprite_pixel,
  output logic           pixel_opaque,
  output logic           sprite_done
);

  localparam int SW = cnt_width(SCALE);
  localparam int RW = cnt_width(HEIGHT + 1);
  localparam logic [SW-1:0] SUB_MAX = SW'(SCALE - 1);
  localparam logic [RW-1:0] ROW_END = RW'(HEIGHT);

  logic [SW-1:0]  x_sub;
  logic [SW-1:0]  y_sub;
  logic [RW-1:0]  row;
  logic           first_pending;
  logic           done;
  logic           fresh;
  logic           step;
  logic [BPP-1:0] buf_head;
  logic [BPP-1:0] pix;

  assign done  = (row == ROW_END);
  assign fresh = (y_sub == '0) && !done;
  assign step  = pixel_valid && (x_sub == SUB_MAX) && !done;

  assign pix          = (done || !pixel_valid) ? '0 : (fresh ? sprite_data : buf_head);
  assign sprite_pixel = pix;
  assign pixel_opaque = (|pix) && !done;
  assign sprite_shift = step && fresh;
  assign sprite_done  = done;

  // Horizontal sub-pixel position within the current sprite pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_sub <= '0;
    end else if (frame_start || line_start) begin
      x_sub <= '0;
    end else if (pixel_valid) begin
      x_sub <= (x_sub == SUB_MAX) ? '0 : x_sub + 1'b1;
    end
  end

  // Vertical position. The first line_start after frame_start only arms the
  // sprite (first_pending) so that line becomes the fresh line of row 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_sub         <= '0;
      row           <= '0;
      first_pending <= 1'b0;
    end else if (frame_start) begin
      y_sub         <= '0;
      row           <= '0;
      first_pending <= 1'b1;
    end else if (line_start) begin
      if (first_pending) begin
        first_pending <= 1'b0;
      end else if (y_sub == SUB_MAX) begin
        y_sub <= '0;
        if (row != ROW_END) begin
          row <= row + 1'b1;
        end
      end else begin
        y_sub <= y_sub + 1'b1;
      end
    end
  end

  // Fresh lines capture sprite_data; repeat lines rotate the stored row.
  sprite_line_buf #(
    .WIDTH (WIDTH),
    .BPP   (BPP)
  ) u_line_buf (
    .clk      (clk),
    .reset    (reset),
    .shift    (step),
    .load_sel (fresh),
    .data_in  (sprite_data),
    .head     (buf_head)
  );

endmodule

// File: tb/tb_sprite_scaler.sv
module tb_sprite_scaler;
  import sprite_pkg::*;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int S  = 2;
  localparam int W1 = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       frame_start = 1'b0, line_start = 1'b0, pixel_valid = 1'b0;
  logic [1:0] sprite_data = '0;
  logic       sprite_shift, pixel_opaque, sprite_done;
  logic [1:0] sprite_pixel;

  logic       f1 = 1'b0, l1 = 1'b0, pv1 = 1'b0;
  logic [1:0] sd1 = '0;
  logic       sh1, op1, dn1;
  logic [1:0] px1;

  sprite_scaler #(.WIDTH(W), .HEIGHT(H), .BPP(2), .SCALE(S)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
    .pixel_valid(pixel_valid), .sprite_data(sprite_data), .sprite_shift(sprite_shift),
    .sprite_pixel(sprite_pixel), .pixel_opaque(pixel_opaque), .sprite_done(sprite_done)
  );

  sprite_scaler #(.WIDTH(W1), .HEIGHT(H), .BPP(2), .SCALE(1)) dut1 (
    .clk(clk), .reset(reset), .frame_start(f1), .line_start(l1),
    .pixel_valid(pv1), .sprite_data(sd1), .sprite_shift(sh1),
    .sprite_pixel(px1), .pixel_opaque(op1), .sprite_done(dn1)
  );

  typedef struct packed {
    logic [1:0] pix;
    logic       shift;
    logic       opaque;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;
  int idx = 0;
  int n_shift = 0;
  int exp_shift = 0;

  // Rows {1,2,3,0} and {3,3,0,1} as the external register presents them.
  pixel_t src [0:7] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd3, 2'd0, 2'd1};

  // Past the end of the sprite the register shows a non-zero colour so any
  // leakage into sprite_pixel after done is visible.
  function automatic pixel_t src_at(input int i);
    return (i >= 0 && i < 8) ? src[i] : pixel_t'(3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  // One display cycle on the main DUT; p < 0 is a cycle outside the sprite.
  task automatic drive_pixel(input int L, input int p);
    exp_t e;
    int r;
    @(negedge clk);
    frame_start = 1'b0;
    line_start  = 1'b0;
    pixel_valid = (p >= 0);
    sprite_data = src_at(idx);
    r = L / S;
    e = '0;
    if (r >= H) begin
      e.done = 1'b1;
    end else if (p >= 0) begin
      e.pix    = src[r*W + p/S];
      e.shift  = (L % S == 0) && (p % S == S - 1);
      e.opaque = (e.pix != 2'd0);
    end
    if (e.shift) exp_shift++;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk($sformatf("L%0d p%0d pixel", L, p), sprite_pixel, e.pix);
    chk($sformatf("L%0d p%0d shift", L, p), sprite_shift, e.shift);
    chk($sformatf("L%0d p%0d opaque", L, p), pixel_opaque, e.opaque);
    chk($sformatf("L%0d p%0d done", L, p), sprite_done, e.done);
    if (sprite_shift) begin
      idx++;
      n_shift++;
    end
  endtask

  task automatic do_line(input int L, input int npix);
    @(negedge clk);
    frame_start = 1'b0;
    line_start  = 1'b1;
    pixel_valid = 1'b0;
    for (int p = 0; p < npix; p++) drive_pixel(L, p);
    drive_pixel(L, -1);
  endtask

  task automatic start_frame(input logic with_line);
    @(negedge clk);
    frame_start = 1'b1;
    line_start  = with_line;
    pixel_valid = 1'b0;
    idx = 0;
  endtask

  task automatic full_frame(input string tag);
    n_shift = 0;
    exp_shift = 0;
    for (int L = 0; L < 5; L++) do_line(L, W * S);
    chk({tag, " shifts"}, n_shift, exp_shift);
    chk({tag, " shifts_total"}, n_shift, W * H);
  endtask

  initial begin
    exp_t e1;
    int n1;

    // Reset state
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst shift", sprite_shift, 1'b0);
    chk("rst pixel", sprite_pixel, 2'd0);
    chk("rst opaque", pixel_opaque, 1'b0);
    chk("rst done", sprite_done, 1'b0);
    chk("rst1 shift", sh1, 1'b0);
    chk("rst1 done", dn1, 1'b0);
    reset = 1'b0;
    drive_pixel(0, -1);

    // Full frame, including the post-sprite line
    start_frame(1'b0);
    full_frame("frameA");

    // frame_start together with line_start in the middle of row 1
    start_frame(1'b0);
    do_line(0, W * S);
    do_line(1, W * S);
    do_line(2, 3);
    start_frame(1'b1);
    full_frame("restart");

    // Asynchronous reset at x_sub=1 of line 2
    start_frame(1'b0);
    do_line(0, W * S);
    do_line(1, W * S);
    @(negedge clk);
    line_start = 1'b1;
    drive_pixel(2, 0);
    @(negedge clk);
    pixel_valid = 1'b1;
    sprite_data = src_at(idx);
    #1;
    chk("prereset shift", sprite_shift, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("async shift", sprite_shift, 1'b0);
    chk("async done", sprite_done, 1'b0);
    pixel_valid = 1'b0;
    #1;
    chk("async pixel", sprite_pixel, 2'd0);
    chk("async opaque", pixel_opaque, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    start_frame(1'b0);
    full_frame("postreset");

    // SCALE=1, WIDTH=8: every valid pixel is a fresh step
    @(negedge clk);
    f1 = 1'b1;
    n1 = 0;
    for (int L = 0; L < 3; L++) begin
      @(negedge clk);
      f1 = 1'b0;
      l1 = 1'b1;
      pv1 = 1'b0;
      for (int p = 0; p < W1; p++) begin
        @(negedge clk);
        l1 = 1'b0;
        pv1 = 1'b1;
        sd1 = 2'($urandom_range(0, 3));
        e1 = '0;
        if (L < H) begin
          e1.pix = sd1;
          e1.shift = 1'b1;
          e1.opaque = (sd1 != 2'd0);
        end else begin
          e1.done = 1'b1;
        end
        sb.push_back(e1);
        #1;
        e1 = sb.pop_front();
        chk($sformatf("s1 L%0d p%0d pixel", L, p), px1, e1.pix);
        chk($sformatf("s1 L%0d p%0d shift", L, p), sh1, e1.shift);
        chk($sformatf("s1 L%0d p%0d opaque", L, p), op1, e1.opaque);
        chk($sformatf("s1 L%0d p%0d done", L, p), dn1, e1.done);
        if (sh1) n1++;
      end
    end
    @(negedge clk);
    pv1 = 1'b0;
    chk("s1 shifts_total", n1, W1 * H);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
